// File: rtl/io_fifo_port.sv
// io_fifo_port
//   Memory-mapped I/O responder with a CPU-filled TX FIFO (drained over a
//   valid/ready handshake) and a producer-filled RX FIFO (drained by CPU reads).
//   Register window at BASE_ADDR (4 words):
//     +0 TXDATA  W: push to TX FIFO (dropped and tx_ovf set when full), R: 0
//     +1 RXDATA  R: RX head, popped at the edge (0 and rx_udf set when empty)
//     +2 STATUS  R: {rx_udf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty}
//                W: write-1-to-clear on bits [5:4]
//     +3 COUNT   R: {rx_count[7:0], tx_count[7:0]}; W: irq mask when enabled
//   Optional feature macro: IO_FIFO_PORT_IRQ_EN adds the irq output and mask.
// Ports:
//   clk, reset (async, active-low)
//   read, write, bus_addr, bus_data (inout, driven only on a selected read)
//   tx_data, tx_valid, tx_ready   : TX consumer handshake
//   rx_data, rx_valid, rx_ready   : RX producer handshake
//   irq                            : only with IO_FIFO_PORT_IRQ_EN
module io_fifo_port #(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 8'h10,
  parameter int                  DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
`ifdef IO_FIFO_PORT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] tx_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_r [DEPTH];
  logic [PW-1:0]         tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CW-1:0]         tx_cnt_r, rx_cnt_r;
  logic                  tx_ovf_r, rx_udf_r;

  logic                  sel_s, rd_s, wr_s;
  logic [1:0]            off_s;
  logic                  tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic                  tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic                  tx_ovf_set_s, rx_udf_set_s, tx_ovf_clr_s, rx_udf_clr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Address decode; read and write together is treated as no access at all.
  assign sel_s = (bus_addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
  assign off_s = bus_addr[1:0];
  assign rd_s  = sel_s & read & ~write;
  assign wr_s  = sel_s & write & ~read;

  assign tx_empty_s = (tx_cnt_r == CW'(0));
  assign tx_full_s  = (tx_cnt_r == CW'(DEPTH));
  assign rx_empty_s = (rx_cnt_r == CW'(0));
  assign rx_full_s  = (rx_cnt_r == CW'(DEPTH));

  // Handshake outputs depend on registered counts only.
  assign tx_valid = ~tx_empty_s;
  assign rx_ready = ~rx_full_s;
  assign tx_data  = tx_empty_s ? {DATA_WIDTH{1'b0}} : tx_mem_r[tx_rd_ptr_r];

  // Full/empty are judged on pre-edge state, so a push to a full FIFO is
  // dropped even when the consumer pops in the same cycle.
  assign tx_push_s    = wr_s & (off_s == 2'd0) & ~tx_full_s;
  assign tx_ovf_set_s = wr_s & (off_s == 2'd0) & tx_full_s;
  assign tx_pop_s     = tx_valid & tx_ready;
  assign rx_push_s    = rx_valid & rx_ready;
  assign rx_pop_s     = rd_s & (off_s == 2'd1) & ~rx_empty_s;
  assign rx_udf_set_s = rd_s & (off_s == 2'd1) & rx_empty_s;
  assign tx_ovf_clr_s = wr_s & (off_s == 2'd2) & bus_data[4];
  assign rx_udf_clr_s = wr_s & (off_s == 2'd2) & bus_data[5];

  // Combinational read mux so the CPU captures data at the same edge.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    case (off_s)
      2'd0: rd_data_s = {DATA_WIDTH{1'b0}};
      2'd1: begin
        if (rx_empty_s) begin
          rd_data_s = {DATA_WIDTH{1'b0}};
        end else begin
          rd_data_s = rx_mem_r[rx_rd_ptr_r];
        end
      end
      2'd2: rd_data_s[5:0] = {rx_udf_r, tx_ovf_r, rx_full_s, rx_empty_s,
                              tx_full_s, tx_empty_s};
      2'd3: begin
        rd_data_s[7:0]  = 8'(tx_cnt_r);
        rd_data_s[15:8] = 8'(rx_cnt_r);
      end
      default: rd_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign bus_data = rd_s ? rd_data_s : {DATA_WIDTH{1'bz}};

  // FIFO storage; contents need no reset because counts gate visibility.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= bus_data;
    if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data;
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_r <= {PW{1'b0}};
      tx_rd_ptr_r <= {PW{1'b0}};
      tx_cnt_r    <= {CW{1'b0}};
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PW'(1);
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + CW'(1);
        2'b01:   tx_cnt_r <= tx_cnt_r - CW'(1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr_r <= {PW{1'b0}};
      rx_rd_ptr_r <= {PW{1'b0}};
      rx_cnt_r    <= {CW{1'b0}};
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PW'(1);
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PW'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + CW'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - CW'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // Sticky error flags; set and clear come from different offsets so never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_r <= 1'b0;
      rx_udf_r <= 1'b0;
    end else begin
      if (tx_ovf_set_s)      tx_ovf_r <= 1'b1;
      else if (tx_ovf_clr_s) tx_ovf_r <= 1'b0;
      if (rx_udf_set_s)      rx_udf_r <= 1'b1;
      else if (rx_udf_clr_s) rx_udf_r <= 1'b0;
    end
  end

`ifdef IO_FIFO_PORT_IRQ_EN
  logic [1:0] mask_r;
  logic       irq_r;

  // Interrupt mask load from COUNT writes and registered irq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= 2'b00;
      irq_r  <= 1'b0;
    end else begin
      if (wr_s && (off_s == 2'd3)) mask_r <= bus_data[1:0];
      irq_r <= (mask_r[0] & ~rx_empty_s) | (mask_r[1] & tx_empty_s);
    end
  end

  assign irq = irq_r;
`endif

endmodule

// File: tb/tb_io_fifo_port.sv
// Directed testbench for io_fifo_port (DEPTH 8, 16-bit data, base 8'h10).
// Inputs change on the falling edge; outputs are sampled before the next
// rising edge.
module tb_io_fifo_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  bus_addr;
  wire  [15:0] bus_data;
  logic        drv_en;
  logic [15:0] drv_data;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
`ifdef IO_FIFO_PORT_IRQ_EN
  logic        irq;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign bus_data = drv_en ? drv_data : 16'hzzzz;

  io_fifo_port #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .BASE_ADDR(8'h10), .DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .bus_addr(bus_addr), .bus_data(bus_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef IO_FIFO_PORT_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    bus_addr = a; drv_data = d; drv_en = 1'b1; write = 1'b1;
    @(negedge clk);
    write = 1'b0; drv_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [15:0] d);
    bus_addr = a; read = 1'b1;
    #1;
    d = bus_data;
    @(negedge clk);
    read = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    reset = 1'b0; read = 1'b0; write = 1'b0; bus_addr = 8'h00;
    drv_en = 1'b0; drv_data = 16'h0000; tx_ready = 1'b0;
    rx_data = 16'h0000; rx_valid = 1'b0;

    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data",  32'(tx_data),  32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    cpu_read(8'h12, rd);
    check("status_reset", 32'(rd), 32'h0005);

    // DUT must not drive the bus when idle or on an unselected read.
    bus_addr = 8'h12; drv_en = 1'b1; drv_data = 16'h5A5A;
    #1;
    check("bus_idle_undriven", 32'(bus_data), 32'h5A5A);
    drv_en = 1'b0;
    @(negedge clk);

    // Fill TX with the consumer stalled.
    cpu_write(8'h10, 16'hA001);
    check("tx_first_visible", {15'h0, tx_valid, tx_data}, {15'h0, 1'b1, 16'hA001});
    for (int i = 1; i < 8; i++) cpu_write(8'h10, 16'hA001 + 16'(i));
    cpu_write(8'h10, 16'hA009);
    cpu_read(8'h12, rd);
    check("status_tx_full_ovf", 32'(rd), 32'h0016);
    cpu_read(8'h13, rd);
    check("count_tx8", 32'(rd), 32'h0008);

    // Drain in order, one word per cycle.
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("tx_drain", {15'h0, tx_valid, tx_data}, {15'h0, 1'b1, 16'hA001 + 16'(k)});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("tx_drained", {15'h0, tx_valid, tx_data}, 32'h0);
    cpu_write(8'h12, 16'h0010);

    // RX producer then CPU reads, including underflow.
    rx_valid = 1'b1; rx_data = 16'h0BEE;
    @(negedge clk);
    rx_data = 16'h0CAF;
    @(negedge clk);
    rx_valid = 1'b0;
    cpu_read(8'h11, rd);
    check("rx_read_0bee", 32'(rd), 32'h0BEE);
    cpu_read(8'h11, rd);
    check("rx_read_0caf", 32'(rd), 32'h0CAF);
    cpu_read(8'h11, rd);
    check("rx_read_empty", 32'(rd), 32'h0000);
    cpu_read(8'h12, rd);
    check("status_rx_udf", 32'(rd), 32'h0025);
    cpu_write(8'h12, 16'h0020);
    cpu_read(8'h12, rd);
    check("status_udf_clr", 32'(rd), 32'h0005);

    // Offer nine words; only eight fit.
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 16'hB000 + 16'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("rx_full_not_ready", 32'(rx_ready), 32'h0);
    cpu_read(8'h13, rd);
    check("count_rx8", 32'(rd), 32'h0800);
    for (int i = 0; i < 4; i++) begin
      cpu_read(8'h11, rd);
      check("rx_read_b00x", 32'(rd), 32'hB000 + 32'(i));
    end

    // Push to a full TX FIFO while the consumer pops: push dropped.
    for (int i = 0; i < 8; i++) cpu_write(8'h10, 16'hC001 + 16'(i));
    tx_ready = 1'b1;
    cpu_write(8'h10, 16'hC009);
    tx_ready = 1'b0;
    cpu_read(8'h13, rd);
    check("count_full_pop", 32'(rd), 32'h0407);
    check("tx_head_c002", 32'(tx_data), 32'hC002);
    cpu_read(8'h12, rd);
    check("status_ovf_again", 32'(rd), 32'h0010);

    // Push and pop on a partly filled FIFO: count unchanged.
    tx_ready = 1'b1;
    cpu_write(8'h10, 16'hC00A);
    tx_ready = 1'b0;
    cpu_read(8'h13, rd);
    check("count_push_pop", 32'(rd), 32'h0407);
    check("tx_head_c003", 32'(tx_data), 32'hC003);

    // read+write together: no drive, no pop.
    bus_addr = 8'h11; read = 1'b1; write = 1'b1; drv_en = 1'b1; drv_data = 16'h1234;
    #1;
    check("rw_illegal_undriven", 32'(bus_data), 32'h1234);
    @(negedge clk);
    write = 1'b0;
    bus_addr = 8'h21; drv_data = 16'h5A5A;
    #1;
    check("unsel_read_undriven", 32'(bus_data), 32'h5A5A);
    @(negedge clk);
    read = 1'b0; drv_en = 1'b0;
    cpu_read(8'h13, rd);
    check("count_after_illegal", 32'(rd), 32'h0407);

    // Bring TX to half full, then reset asynchronously mid-cycle.
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tx_ready = 1'b0;
    cpu_read(8'h13, rd);
    check("count_half", 32'(rd), 32'h0404);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("async_rst_tx_data",  32'(tx_data),  32'h0);
    check("async_rst_rx_ready", 32'(rx_ready), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cpu_read(8'h13, rd);
    check("count_post_rst", 32'(rd), 32'h0000);
    cpu_read(8'h12, rd);
    check("status_post_rst", 32'(rd), 32'h0005);
    cpu_write(8'h10, 16'hD001);
    check("tx_post_rst", {15'h0, tx_valid, tx_data}, {15'h0, 1'b1, 16'hD001});

`ifdef IO_FIFO_PORT_IRQ_EN
    cpu_write(8'h13, 16'h0001);
    check("irq_masked_idle", 32'(irq), 32'h0);
    rx_valid = 1'b1; rx_data = 16'hE001;
    @(negedge clk);
    rx_valid = 1'b0;
    check("irq_not_yet", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    cpu_read(8'h11, rd);
    check("irq_rx_read", 32'(rd), 32'hE001);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
